// File: rtl/bus1mhz_jim_responder.sv
// BBC 1MHz bus responder: FRED register window, JIM paging registers
// (&FCFF/&FCFE) and &FDxx host cycles mapped onto a req/ack SRAM port.
//
// Ports:
//   clk50, rst                       system clock, sync active-high reset
//   clke, rnw, pgfc_n, pgfd_n        asynchronous host strobes
//   bus_addr, bus_data_in            host address / write data
//   bus_data_out, bus_data_oe        read data and pin drive enable
//   reg_wr, reg_addr, reg_wdata      application register write port
//   reg_rdata                        application register read data
//   ram_req, ram_we, ram_addr,
//   ram_wdata, ram_rdata, ram_ack    external SRAM request port
//   jim_en                           JIM paging enabled
//
// Optional feature macro: JIM_AUTOINC_EN (page auto-increment on &FDFF).

module bus1mhz_jim_responder #(
    parameter logic [7:0] REG_BASE  = 8'hA0,
    parameter int         NUM_REGS  = 9,
    parameter logic [5:0] JIM_DEVID = 6'h32,
    parameter int         RAM_AW    = 19
) (
    input  logic              clk50,
    input  logic              rst,
    input  logic              clke,
    input  logic              rnw,
    input  logic              pgfc_n,
    input  logic              pgfd_n,
    input  logic [7:0]        bus_addr,
    input  logic [7:0]        bus_data_in,
    output logic [7:0]        bus_data_out,
    output logic              bus_data_oe,
    output logic              reg_wr,
    output logic [3:0]        reg_addr,
    output logic [7:0]        reg_wdata,
    input  logic [7:0]        reg_rdata,
    output logic              ram_req,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    input  logic              ram_ack,
    output logic              jim_en
);

    localparam logic [7:0] NREG = 8'(NUM_REGS);

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        RD_HOLD,
        WR_REQ
    } state_t;

    // Two-flop synchronisers; strobes idle at their inactive level.
    logic [1:0] clke_s;
    logic [1:0] rnw_s;
    logic [1:0] pgfc_s;
    logic [1:0] pgfd_s;
    logic       clke_q;

    always_ff @(posedge clk50) begin
        if (rst) begin
            clke_s <= 2'b00;
            rnw_s  <= 2'b11;
            pgfc_s <= 2'b11;
            pgfd_s <= 2'b11;
            clke_q <= 1'b0;
        end else begin
            clke_s <= {clke_s[0], clke};
            rnw_s  <= {rnw_s[0], rnw};
            pgfc_s <= {pgfc_s[0], pgfc_n};
            pgfd_s <= {pgfd_s[0], pgfd_n};
            clke_q <= clke_s[1];
        end
    end

    logic              clke_sy;
    logic              rnw_sy;
    logic              rise;
    logic              fall;
    logic              fsel;
    logic              fwin;
    logic              jsel;
    logic [7:0]        reg_off;
    logic              new_rd;
    logic              new_wr;
    logic              new_v;
    logic [RAM_AW-1:0] new_addr;
    logic [1:0]        page_hi;
    logic [7:0]        page_lo;
    logic [7:0]        rdata_q;

    state_t            state;
    logic              pend_v;
    logic              pend_we;
    logic [RAM_AW-1:0] pend_addr;
    logic [7:0]        pend_data;

    always_comb begin
        clke_sy  = clke_s[1];
        rnw_sy   = rnw_s[1];
        rise     = clke_sy & ~clke_q;
        fall     = ~clke_sy & clke_q;
        fsel     = ~pgfc_s[1];
        reg_off  = bus_addr - REG_BASE;
        fwin     = fsel & (reg_off < NREG);
        jsel     = ~pgfd_s[1] & jim_en;
        new_rd   = rise & jsel & rnw_sy;
        new_wr   = fall & jsel & ~rnw_sy;
        new_v    = new_rd | new_wr;
        // SRAM MSB stays zero; paging supplies the rest.
        new_addr = RAM_AW'({page_hi, page_lo, bus_addr});
    end

`ifdef JIM_AUTOINC_EN
    // A write is accepted unless the single pending slot is full.
    logic wr_accept;
    logic inc_fire;

    always_comb begin
        wr_accept = (state == IDLE) |
                    ((state == WR_REQ) & (ram_ack | ~pend_v | ~pend_we));
        inc_fire  = fall & jsel & (bus_addr == 8'hFF) &
                    (rnw_sy ? ((state == RD_REQ) | (state == RD_HOLD))
                            : wr_accept);
    end
`endif

    // Register port and paging registers.
    always_ff @(posedge clk50) begin
        if (rst) begin
            reg_wr    <= 1'b0;
            reg_addr  <= 4'h0;
            reg_wdata <= 8'h00;
            jim_en    <= 1'b0;
            page_hi   <= 2'b00;
            page_lo   <= 8'h00;
        end else begin
            reg_wr <= 1'b0;
            // Track the window index so reg_rdata is ready for reads.
            if (fwin)
                reg_addr <= reg_off[3:0];
            if (fall && fwin && !rnw_sy) begin
                reg_wr    <= 1'b1;
                reg_wdata <= bus_data_in;
            end
            if (fall && fsel && !rnw_sy && bus_addr == 8'hFF) begin
                if (bus_data_in[7:2] == JIM_DEVID) begin
                    jim_en  <= 1'b1;
                    page_hi <= bus_data_in[1:0];
                end else begin
                    jim_en  <= 1'b0;
                end
            end else if (fall && fsel && !rnw_sy && bus_addr == 8'hFE) begin
                page_lo <= bus_data_in;
            end
`ifdef JIM_AUTOINC_EN
            else if (inc_fire) begin
                {page_hi, page_lo} <= {page_hi, page_lo} + 10'd1;
            end
`endif
        end
    end

    // SRAM request FSM.
    always_ff @(posedge clk50) begin
        if (rst) begin
            state     <= IDLE;
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= 8'h00;
            rdata_q   <= 8'h00;
            pend_v    <= 1'b0;
            pend_we   <= 1'b0;
            pend_addr <= '0;
            pend_data <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (new_rd) begin
                        ram_req  <= 1'b1;
                        ram_we   <= 1'b0;
                        ram_addr <= new_addr;
                        state    <= RD_REQ;
                    end else if (new_wr) begin
                        ram_req   <= 1'b1;
                        ram_we    <= 1'b1;
                        ram_addr  <= new_addr;
                        ram_wdata <= bus_data_in;
                        state     <= WR_REQ;
                    end
                end
                RD_REQ: begin
                    if (ram_ack) begin
                        rdata_q <= ram_rdata;
                        ram_req <= 1'b0;
                        state   <= fall ? IDLE : RD_HOLD;
                    end else if (fall) begin
                        // Host cycle over: abandon, host saw old latch.
                        ram_req <= 1'b0;
                        ram_we  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                RD_HOLD: begin
                    if (fall)
                        state <= IDLE;
                end
                WR_REQ: begin
                    if (ram_ack) begin
                        // A pending read whose host cycle ended is dropped.
                        if (pend_v && !(fall && !pend_we)) begin
                            ram_addr  <= pend_addr;
                            ram_we    <= pend_we;
                            ram_wdata <= pend_data;
                            state     <= pend_we ? WR_REQ : RD_REQ;
                            pend_v    <= new_v;
                            pend_we   <= new_wr;
                            pend_addr <= new_addr;
                            pend_data <= bus_data_in;
                        end else if (new_v) begin
                            ram_addr  <= new_addr;
                            ram_we    <= new_wr;
                            ram_wdata <= bus_data_in;
                            state     <= new_wr ? WR_REQ : RD_REQ;
                            pend_v    <= 1'b0;
                        end else begin
                            ram_req <= 1'b0;
                            ram_we  <= 1'b0;
                            pend_v  <= 1'b0;
                            state   <= IDLE;
                        end
                    end else if (new_v && (!pend_v || (fall && !pend_we))) begin
                        pend_v    <= 1'b1;
                        pend_we   <= new_wr;
                        pend_addr <= new_addr;
                        pend_data <= bus_data_in;
                    end else if (fall && pend_v && !pend_we) begin
                        pend_v <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data drive; clke_sy low (fall onward) releases the bus.
    always_comb begin
        bus_data_oe  = 1'b0;
        bus_data_out = 8'h00;
        if (clke_sy && rnw_sy) begin
            if (fwin) begin
                bus_data_oe  = 1'b1;
                bus_data_out = reg_rdata;
            end else if (fsel && jim_en && bus_addr == 8'hFF) begin
                bus_data_oe  = 1'b1;
                bus_data_out = {JIM_DEVID, page_hi};
            end else if (fsel && jim_en && bus_addr == 8'hFE) begin
                bus_data_oe  = 1'b1;
                bus_data_out = page_lo;
            end else if (jsel) begin
                bus_data_oe  = 1'b1;
                bus_data_out = rdata_q;
            end
        end
    end

endmodule

// File: tb/tb_bus1mhz_jim_responder.sv
// Directed bench for bus1mhz_jim_responder: host bus cycles, register
// window, JIM paging and a req/ack SRAM model with adjustable latency.

module tb_bus1mhz_jim_responder;

    logic        clk50 = 1'b0;
    logic        rst = 1'b1;
    logic        clke = 1'b0;
    logic        rnw = 1'b1;
    logic        pgfc_n = 1'b1;
    logic        pgfd_n = 1'b1;
    logic [7:0]  bus_addr = 8'h00;
    logic [7:0]  bus_data_in = 8'h00;
    logic [7:0]  bus_data_out;
    logic        bus_data_oe;
    logic        reg_wr;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic        ram_req;
    logic        ram_we;
    logic [18:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;
    logic        ram_ack = 1'b0;
    logic        jim_en;

    int checks = 0;
    int failures = 0;

    bus1mhz_jim_responder dut (
        .clk50       (clk50),
        .rst         (rst),
        .clke        (clke),
        .rnw         (rnw),
        .pgfc_n      (pgfc_n),
        .pgfd_n      (pgfd_n),
        .bus_addr    (bus_addr),
        .bus_data_in (bus_data_in),
        .bus_data_out(bus_data_out),
        .bus_data_oe (bus_data_oe),
        .reg_wr      (reg_wr),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .ram_req     (ram_req),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .ram_ack     (ram_ack),
        .jim_en      (jim_en)
    );

    always #10 clk50 = ~clk50;

    // Application register file model: value encodes its own index.
    assign reg_rdata = {4'hA, reg_addr};

    // SRAM model
    logic [7:0] mem [int];
    int         ack_delay = 3;
    logic       ack_en = 1'b1;
    int         ack_cnt = 0;
    int         wr_count = 0;
    int         rd_count = 0;
    int         last_addr = 0;
    logic       last_we = 1'b0;
    logic [7:0] last_wdata = 8'h00;

    always @(negedge clk50) begin
        if (ram_ack) begin
            ram_ack = 1'b0;
            ack_cnt = 0;
        end else if (ram_req && ack_en) begin
            ack_cnt++;
            if (ack_cnt >= ack_delay) begin
                ack_cnt   = 0;
                ram_ack   = 1'b1;
                last_addr = int'(ram_addr);
                last_we   = ram_we;
                if (ram_we) begin
                    mem[int'(ram_addr)] = ram_wdata;
                    last_wdata = ram_wdata;
                    wr_count++;
                end else begin
                    ram_rdata = mem.exists(int'(ram_addr)) ?
                                mem[int'(ram_addr)] : 8'h00;
                    rd_count++;
                end
            end
        end else begin
            ack_cnt = 0;
        end
    end

    // Output monitors
    int         regwr_count = 0;
    logic [3:0] last_reg_addr = 4'h0;
    logic [7:0] last_reg_wdata = 8'h00;
    int         req_count = 0;
    logic       req_prev = 1'b0;

    always @(negedge clk50) begin
        if (reg_wr) begin
            regwr_count++;
            last_reg_addr  = reg_addr;
            last_reg_wdata = reg_wdata;
        end
        if (ram_req && !req_prev)
            req_count++;
        req_prev = ram_req;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_at(input int a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    task automatic host_wr(input logic fd, input logic [7:0] a,
                           input logic [7:0] d);
        @(negedge clk50);
        pgfc_n      = fd;
        pgfd_n      = ~fd;
        rnw         = 1'b0;
        bus_addr    = a;
        bus_data_in = d;
        repeat (5) @(negedge clk50);
        clke = 1'b1;
        repeat (24) @(negedge clk50);
        clke = 1'b0;
        repeat (25) @(negedge clk50);
        pgfc_n = 1'b1;
        pgfd_n = 1'b1;
        rnw    = 1'b1;
    endtask

    task automatic host_rd(input logic fd, input logic [7:0] a,
                           output logic [7:0] d, output logic oe_pre,
                           output logic oe_hi, output logic oe_after,
                           output logic req_hi, output logic req_after);
        @(negedge clk50);
        pgfc_n   = fd;
        pgfd_n   = ~fd;
        rnw      = 1'b1;
        bus_addr = a;
        repeat (5) @(negedge clk50);
        oe_pre = bus_data_oe;
        clke   = 1'b1;
        repeat (20) @(negedge clk50);
        d      = bus_data_out;
        oe_hi  = bus_data_oe;
        req_hi = ram_req;
        repeat (4) @(negedge clk50);
        clke = 1'b0;
        repeat (4) @(negedge clk50);
        oe_after  = bus_data_oe;
        req_after = ram_req;
        repeat (21) @(negedge clk50);
        pgfc_n = 1'b1;
        pgfd_n = 1'b1;
    endtask

    logic [7:0] rd;
    logic       oe_pre, oe_hi, oe_after, req_hi, req_after;

    initial begin
        repeat (5) @(negedge clk50);
        rst = 1'b0;
        @(negedge clk50);
        chk("reset_oe", 32'(bus_data_oe), 32'd0);
        chk("reset_dout", 32'(bus_data_out), 32'h00);
        chk("reset_reg_wr", 32'(reg_wr), 32'd0);
        chk("reset_ram_req", 32'(ram_req), 32'd0);
        chk("reset_jim_en", 32'(jim_en), 32'd0);
        chk("reset_ram_addr", 32'(ram_addr), 32'h0);

        // Register window write
        host_wr(1'b0, 8'hA8, 8'h04);
        chk("t1_regwr_pulses", 32'(regwr_count), 32'd1);
        chk("t1_reg_addr", 32'(last_reg_addr), 32'd8);
        chk("t1_reg_wdata", 32'(last_reg_wdata), 32'h04);
        chk("t1_no_ram_req", 32'(req_count), 32'd0);

        // Window edges: A9 outside, A0 inside
        host_wr(1'b0, 8'hA9, 8'h11);
        chk("win_above", 32'(regwr_count), 32'd1);
        host_wr(1'b0, 8'hA0, 8'h33);
        chk("win_base_count", 32'(regwr_count), 32'd2);
        chk("win_base_addr", 32'(last_reg_addr), 32'd0);

        host_rd(1'b0, 8'hA3, rd, oe_pre, oe_hi, oe_after, req_hi, req_after);
        chk("reg_read_data", 32'(rd), 32'hA3);
        chk("reg_read_oe", 32'(oe_hi), 32'd1);

        // JIM enable and paged SRAM write
        host_wr(1'b0, 8'hFF, 8'hC9);
        chk("t2_jim_en", 32'(jim_en), 32'd1);
        host_wr(1'b0, 8'hFE, 8'h12);
        host_wr(1'b1, 8'hAB, 8'h5A);
        chk("t2_wr_count", 32'(wr_count), 32'd1);
        chk("t2_ram_addr", 32'(last_addr), 32'h112AB);
        chk("t2_ram_we", 32'(last_we), 32'd1);
        chk("t2_ram_wdata", 32'(last_wdata), 32'h5A);
        host_rd(1'b0, 8'hFF, rd, oe_pre, oe_hi, oe_after, req_hi, req_after);
        chk("t2_fcff_read", 32'(rd), 32'hC9);
        host_rd(1'b0, 8'hFE, rd, oe_pre, oe_hi, oe_after, req_hi, req_after);
        chk("t2_fcfe_read", 32'(rd), 32'h12);

        // SRAM read
        host_rd(1'b1, 8'hAB, rd, oe_pre, oe_hi, oe_after, req_hi, req_after);
        chk("t3_data", 32'(rd), 32'h5A);
        chk("t3_oe_before_rise", 32'(oe_pre), 32'd0);
        chk("t3_oe_high", 32'(oe_hi), 32'd1);
        chk("t3_oe_after_fall", 32'(oe_after), 32'd0);
        chk("t3_ram_addr", 32'(last_addr), 32'h112AB);
        chk("t3_ram_we", 32'(last_we), 32'd0);

        // JIM disable
        host_wr(1'b0, 8'hFF, 8'h00);
        chk("t4_jim_en", 32'(jim_en), 32'd0);
        host_wr(1'b1, 8'h10, 8'h99);
        chk("t4_no_ram_req", 32'(req_count), 32'd2);
        host_rd(1'b0, 8'hFF, rd, oe_pre, oe_hi, oe_after, req_hi, req_after);
        chk("t4_fcff_oe", 32'(oe_hi), 32'd0);

        // Read abandoned at fall (ack withheld)
        host_wr(1'b0, 8'hFF, 8'hC8);
        ack_en = 1'b0;
        host_rd(1'b1, 8'h20, rd, oe_pre, oe_hi, oe_after, req_hi, req_after);
        ack_en = 1'b1;
        chk("t5_req_high", 32'(req_hi), 32'd1);
        chk("t5_oe_high", 32'(oe_hi), 32'd1);
        chk("t5_old_latch", 32'(rd), 32'h5A);
        chk("t5_req_dropped", 32'(req_after), 32'd0);
        host_wr(1'b1, 8'h21, 8'h77);
        chk("t5_idle_wr_addr", 32'(last_addr), 32'h01221);
        chk("t5_idle_wr_data", 32'(last_wdata), 32'h77);

        // Second write arrives while first is still in flight
        ack_delay = 80;
        host_wr(1'b1, 8'h40, 8'hA1);
        host_wr(1'b1, 8'h41, 8'hB2);
        repeat (200) @(negedge clk50);
        ack_delay = 3;
        chk("pend_wr_count", 32'(wr_count), 32'd4);
        chk("pend_first", 32'(mem_at(32'h01240)), 32'hA1);
        chk("pend_second", 32'(mem_at(32'h01241)), 32'hB2);

`ifdef JIM_AUTOINC_EN
        host_wr(1'b0, 8'hFF, 8'hCB);
        host_wr(1'b0, 8'hFE, 8'hFF);
        host_wr(1'b1, 8'hFF, 8'h11);
        chk("t6_ram_addr", 32'(last_addr), 32'h3FFFF);
        host_rd(1'b0, 8'hFE, rd, oe_pre, oe_hi, oe_after, req_hi, req_after);
        chk("t6_page_lo", 32'(rd), 32'h00);
        host_rd(1'b0, 8'hFF, rd, oe_pre, oe_hi, oe_after, req_hi, req_after);
        chk("t6_page_hi", 32'(rd), 32'hC8);
`else
        host_wr(1'b1, 8'hFF, 8'h11);
        chk("fdff_plain_addr", 32'(last_addr), 32'h012FF);
        host_rd(1'b0, 8'hFE, rd, oe_pre, oe_hi, oe_after, req_hi, req_after);
        chk("fdff_page_kept", 32'(rd), 32'h12);
`endif

        // Reset in the middle of an SRAM read
        ack_en = 1'b0;
        @(negedge clk50);
        pgfd_n   = 1'b0;
        rnw      = 1'b1;
        bus_addr = 8'h30;
        repeat (5) @(negedge clk50);
        clke = 1'b1;
        repeat (10) @(negedge clk50);
        chk("rst_req_before", 32'(ram_req), 32'd1);
        rst = 1'b1;
        @(negedge clk50);
        chk("rst_req_dropped", 32'(ram_req), 32'd0);
        chk("rst_jim_en", 32'(jim_en), 32'd0);
        clke = 1'b0;
        repeat (5) @(negedge clk50);
        rst    = 1'b0;
        pgfd_n = 1'b1;
        ack_en = 1'b1;
        repeat (5) @(negedge clk50);
        chk("rst_oe", 32'(bus_data_oe), 32'd0);
        chk("rst_req_idle", 32'(ram_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
